// File: rtl/comm_pkg.sv
// Shared definitions for the comm FPGA transmit schedulers.
// The state encoding is visible to software through the SPI status word.
package comm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_LAG    = 2'd3
    } tx_state_e;

    // Position of the scheduler state field inside the SPI status word
    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_STATE_W   = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: first set request strictly after ptr,
// wrapping modulo PORTS, so the last winner gets lowest priority.
module rr_arbiter #(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0]         req_i,
    input  logic [$clog2(PORTS)-1:0] ptr_i,
    output logic                     any_o,
    output logic [PORTS-1:0]         onehot_o,
    output logic [$clog2(PORTS)-1:0] idx_o
);

    localparam int IW = $clog2(PORTS);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    always_comb begin
        any_o    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        w_sum    = '0;
        w_cand   = '0;
        // ptr+i spans up to 2*PORTS-1, one extra bit keeps the wrap exact
        for (int i = 1; i <= PORTS; i++) begin
            w_sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(PORTS))
                w_sum = w_sum - (IW+1)'(PORTS);
            w_cand = w_sum[IW-1:0];
            if (!any_o && req_i[w_cand]) begin
                any_o            = 1'b1;
                idx_o            = w_cand;
                onehot_o[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/comm_tx_sched.sv
// Half-duplex RS-485 transmit scheduler: round-robin grant of one shared UART
// serializer with TXEN lead/lag guard times and an ACTIVE-phase timeout.
module comm_tx_sched
    import comm_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int LEAD  = 8,
    parameter int LAG   = 8,
    parameter int TMO   = 65535
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [PORTS-1:0]         req_i,
    input  logic [PORTS-1:0]         mask_i,
    input  logic                     done_i,
    output logic [PORTS-1:0]         txen_o,
    output logic [$clog2(PORTS)-1:0] sel_o,
    output logic                     start_o,
    output logic [PORTS-1:0]         gnt_o,
    output logic [1:0]               state_o,
    output logic                     tmo_o
);

    localparam int IW = $clog2(PORTS);
    localparam int CW = $clog2(max3(LEAD, LAG, TMO) + 1);

    localparam logic [CW-1:0] LEAD_END = CW'(LEAD - 1);
    localparam logic [CW-1:0] LAG_END  = CW'(LAG - 1);
    localparam logic [CW-1:0] TMO_END  = CW'(TMO - 1);

    tx_state_e        r_state, w_nstate;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic [IW-1:0]    r_ptr, w_ptr_nx;
    logic [IW-1:0]    r_sel, w_sel_nx;
    logic [PORTS-1:0] r_txen, w_txen_nx;
    logic [PORTS-1:0] r_gnt, w_gnt_nx;
    logic             r_start, w_start_nx;
    logic             r_tmo, w_tmo_nx;

    logic             w_any;
    logic [PORTS-1:0] w_onehot;
    logic [IW-1:0]    w_idx;

    rr_arbiter #(.PORTS(PORTS)) u_arb (
        .req_i    (req_i & mask_i),
        .ptr_i    (r_ptr),
        .any_o    (w_any),
        .onehot_o (w_onehot),
        .idx_o    (w_idx)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= IW'(PORTS - 1);
            r_sel   <= '0;
            r_txen  <= '0;
            r_gnt   <= '0;
            r_start <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_cnt_nx;
            r_ptr   <= w_ptr_nx;
            r_sel   <= w_sel_nx;
            r_txen  <= w_txen_nx;
            r_gnt   <= w_gnt_nx;
            r_start <= w_start_nx;
            r_tmo   <= w_tmo_nx;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight off a flop
    always_comb begin
        w_nstate   = r_state;
        w_cnt_nx   = r_cnt + CW'(1);
        w_ptr_nx   = r_ptr;
        w_sel_nx   = r_sel;
        w_txen_nx  = r_txen;
        w_gnt_nx   = r_gnt;
        w_start_nx = 1'b0;
        w_tmo_nx   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx  = '0;
                w_txen_nx = '0;
                w_gnt_nx  = '0;
                if (w_any) begin
                    w_nstate  = ST_LEAD;
                    w_ptr_nx  = w_idx;
                    w_sel_nx  = w_idx;
                    w_txen_nx = w_onehot;
                    w_gnt_nx  = w_onehot;
                end
            end
            ST_LEAD: begin
                // Requester gave up before the line was ours: release without lag
                if (!req_i[r_sel] || !mask_i[r_sel]) begin
                    w_nstate  = ST_IDLE;
                    w_cnt_nx  = '0;
                    w_txen_nx = '0;
                    w_gnt_nx  = '0;
                end else if (r_cnt == LEAD_END) begin
                    w_nstate   = ST_ACTIVE;
                    w_cnt_nx   = '0;
                    w_start_nx = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (done_i) begin
                    w_nstate = ST_LAG;
                    w_cnt_nx = '0;
                    w_gnt_nx = '0;
                end else if (r_cnt == TMO_END) begin
                    w_nstate = ST_LAG;
                    w_cnt_nx = '0;
                    w_gnt_nx = '0;
                    w_tmo_nx = 1'b1;
                end
            end
            ST_LAG: begin
                if (r_cnt == LAG_END) begin
                    w_nstate  = ST_IDLE;
                    w_cnt_nx  = '0;
                    w_txen_nx = '0;
                end
            end
            default: begin
                w_nstate  = ST_IDLE;
                w_cnt_nx  = '0;
                w_txen_nx = '0;
                w_gnt_nx  = '0;
            end
        endcase
    end

    assign txen_o  = r_txen;
    assign gnt_o   = r_gnt;
    assign sel_o   = r_sel;
    assign start_o = r_start;
    assign tmo_o   = r_tmo;
    assign state_o = r_state;

endmodule

// File: tb/tb_comm_tx_sched.sv
// Directed bench for comm_tx_sched with hand-computed cycle expectations.
module tb_comm_tx_sched;

    localparam int PORTS = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [3:0] req_i = '0;
    logic [3:0] mask_i = 4'hF;
    logic       done_i = 1'b0;
    logic [3:0] txen_o;
    logic [1:0] sel_o;
    logic       start_o;
    logic [3:0] gnt_o;
    logic [1:0] state_o;
    logic       tmo_o;

    int errors = 0;
    int checks = 0;
    int viol   = 0;
    logic [1:0] prev_state = 2'd0;

    comm_tx_sched #(.PORTS(PORTS), .LEAD(8), .LAG(8), .TMO(100)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .mask_i  (mask_i),
        .done_i  (done_i),
        .txen_o  (txen_o),
        .sel_o   (sel_o),
        .start_o (start_o),
        .gnt_o   (gnt_o),
        .state_o (state_o),
        .tmo_o   (tmo_o)
    );

    always #5 clk_i = ~clk_i;

    // Protocol watcher: TXEN one-hot-or-zero, grant implies matching TXEN, LEAD only from IDLE
    always @(negedge clk_i) begin
        if (rst_i) begin
            if ($countones(txen_o) > 1) viol++;
            if (gnt_o != 4'd0 && gnt_o != txen_o) viol++;
            if (state_o == 2'd1 && prev_state != 2'd1 && prev_state != 2'd0) viol++;
        end
        prev_state = state_o;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!start_o && n < 300) begin
            tick(1);
            n++;
        end
        chk("start_seen", 32'(start_o), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (state_o != 2'd0 && n < 300) begin
            tick(1);
            n++;
        end
        chk("idle_seen", 32'(state_o), 32'd0);
    endtask

    task automatic run_frame(input int port, input int dly);
        wait_start();
        chk("frame_gnt", 32'(gnt_o), 32'(1) << port);
        chk("frame_sel", 32'(sel_o), 32'(port));
        tick(dly);
        done_i = 1'b1;
        tick(1);
        done_i = 1'b0;
        chk("frame_lag", 32'(state_o), 32'd3);
        chk("frame_lag_gnt", 32'(gnt_o), 32'd0);
    endtask

    initial begin
        // Reset
        tick(3);
        chk("rst_txen", 32'(txen_o), 32'd0);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_start", 32'(start_o), 32'd0);
        rst_i = 1'b1;
        tick(1);

        // Single frame, port 0; stray done in LEAD is ignored
        req_i = 4'b0001;
        tick(1);
        chk("t1_txen_c1", 32'(txen_o), 32'h1);
        chk("t1_gnt_c1", 32'(gnt_o), 32'h1);
        chk("t1_state_c1", 32'(state_o), 32'd1);
        tick(2);
        done_i = 1'b1;
        tick(1);
        done_i = 1'b0;
        chk("t1_done_in_lead", 32'(state_o), 32'd1);
        tick(4);
        chk("t1_start_c8", 32'(start_o), 32'd0);
        tick(1);
        chk("t1_start_c9", 32'(start_o), 32'd1);
        chk("t1_state_c9", 32'(state_o), 32'd2);
        tick(1);
        chk("t1_start_c10", 32'(start_o), 32'd0);
        tick(10);
        done_i = 1'b1;
        tick(1);
        done_i = 1'b0;
        req_i  = 4'b0000;
        chk("t1_state_c21", 32'(state_o), 32'd3);
        chk("t1_txen_c21", 32'(txen_o), 32'h1);
        chk("t1_gnt_c21", 32'(gnt_o), 32'h0);
        tick(7);
        chk("t1_txen_c28", 32'(txen_o), 32'h1);
        tick(1);
        chk("t1_txen_c29", 32'(txen_o), 32'h0);
        chk("t1_state_c29", 32'(state_o), 32'd0);

        // Round robin across all ports from fresh reset
        rst_i = 1'b0;
        tick(1);
        rst_i = 1'b1;
        req_i = 4'b1111;
        run_frame(0, 5);
        run_frame(1, 5);
        run_frame(2, 5);
        run_frame(3, 5);
        run_frame(0, 5);
        req_i = 4'b0000;
        wait_idle();

        // Masked port never granted; done coinciding with start is honoured
        rst_i = 1'b0;
        tick(1);
        rst_i  = 1'b1;
        req_i  = 4'b0101;
        mask_i = 4'b0001;
        run_frame(0, 0);
        run_frame(0, 2);
        run_frame(0, 5);
        req_i  = 4'b0000;
        mask_i = 4'hF;
        wait_idle();

        // Abort in LEAD advances ptr past port 1
        req_i = 4'b0010;
        tick(1);
        chk("t4_gnt", 32'(gnt_o), 32'h2);
        tick(3);
        chk("t4_state_lead", 32'(state_o), 32'd1);
        req_i = 4'b0000;
        tick(1);
        chk("t4_abort_state", 32'(state_o), 32'd0);
        chk("t4_abort_txen", 32'(txen_o), 32'h0);
        chk("t4_abort_start", 32'(start_o), 32'd0);
        req_i = 4'b0110;
        tick(1);
        chk("t4_next_gnt", 32'(gnt_o), 32'h4);
        chk("t4_next_sel", 32'(sel_o), 32'd2);
        run_frame(2, 3);
        req_i = 4'b0000;
        wait_idle();

        // Timeout: ptr=2, so a request on port 0 wins after wrap
        req_i = 4'b0001;
        wait_start();
        tick(99);
        chk("t5_tmo_early", 32'(tmo_o), 32'd0);
        chk("t5_state_active", 32'(state_o), 32'd2);
        tick(1);
        chk("t5_tmo_pulse", 32'(tmo_o), 32'd1);
        chk("t5_state_lag", 32'(state_o), 32'd3);
        chk("t5_txen_lag", 32'(txen_o), 32'h1);
        tick(1);
        chk("t5_tmo_clear", 32'(tmo_o), 32'd0);
        req_i = 4'b0000;
        tick(6);
        chk("t5_txen_c107", 32'(txen_o), 32'h1);
        tick(1);
        chk("t5_txen_c108", 32'(txen_o), 32'h0);
        chk("t5_state_c108", 32'(state_o), 32'd0);

        // Reset in ACTIVE, then arbitration restarts at port 0
        req_i = 4'b0010;
        wait_start();
        chk("t6_gnt", 32'(gnt_o), 32'h2);
        tick(1);
        rst_i = 1'b0;
        req_i = 4'b0011;
        tick(1);
        chk("t6_rst_txen", 32'(txen_o), 32'h0);
        chk("t6_rst_gnt", 32'(gnt_o), 32'h0);
        chk("t6_rst_state", 32'(state_o), 32'd0);
        chk("t6_rst_sel", 32'(sel_o), 32'd0);
        chk("t6_rst_start", 32'(start_o), 32'd0);
        rst_i = 1'b1;
        tick(1);
        chk("t6_regrant", 32'(gnt_o), 32'h1);
        chk("t6_regrant_sel", 32'(sel_o), 32'd0);

        chk("protocol_viol", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
